irq_ctrl: RTL and testbench



---
 rtl/irq_pkg.sv | 24 ++
 rtl/irq_prio_enc.sv | 23 ++
 rtl/irq_ctrl.sv | 121 ++++++++++++
 tb/tb_irq_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared interrupt constants: source indices, default register addresses and vector layout.
package irq_pkg;

  localparam int unsigned IRQ_VBLANK = 0;
  localparam int unsigned IRQ_LCDC   = 1;
  localparam int unsigned IRQ_TIMER  = 2;
  localparam int unsigned IRQ_SERIAL = 3;
  localparam int unsigned IRQ_JOYPAD = 4;

  localparam logic [15:0] IE_ADDR_DEFAULT    = 16'hFFFF;
  localparam logic [15:0] IF_ADDR_DEFAULT    = 16'hFF0F;
  localparam logic [7:0]  VEC_BASE_DEFAULT   = 8'h40;
  localparam logic [7:0]  VEC_STRIDE_DEFAULT = 8'h08;

  // Vector address for a source index; wraps at 8 bits.
  function automatic logic [7:0] irq_vec_calc(input logic [7:0] base,
                                              input logic [7:0] stride,
                                              input logic [7:0] idx);
    logic [7:0] prod;
    prod = 8'(idx * stride);
    return 8'(base + prod);
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: index of the first set request plus a valid flag.
module irq_prio_enc #(
  parameter int unsigned N = 5,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = IdxW'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// N-source interrupt controller: IE/IF registers, fixed-priority vectoring and CPU ack.
// Define IRQ_EDGE_DETECT_EN to treat irq_req_i as levels with rising-edge capture.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned N_IRQ      = 5,
  parameter logic [15:0] IE_ADDR    = IE_ADDR_DEFAULT,
  parameter logic [15:0] IF_ADDR    = IF_ADDR_DEFAULT,
  parameter logic [7:0]  VEC_BASE   = VEC_BASE_DEFAULT,
  parameter logic [7:0]  VEC_STRIDE = VEC_STRIDE_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [15:0]      a_i,
  input  logic [7:0]       din_i,
  output logic [7:0]       dout_o,
  input  logic             rd_i,
  input  logic             wr_i,
  output logic             hit_o,
  input  logic [N_IRQ-1:0] irq_req_i,
  output logic             irq_pending_o,
  output logic [7:0]       irq_vector_o,
  input  logic             irq_ack_i,
  output logic [N_IRQ-1:0] ie_out_o,
  output logic [N_IRQ-1:0] if_out_o
);

  localparam int unsigned IdxW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  logic [N_IRQ-1:0] ie_q, ie_d;
  logic [N_IRQ-1:0] if_q, if_d;
  logic             pending_q, pending_d;
  logic [7:0]       vector_q, vector_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [N_IRQ-1:0] set_vec;
  logic [IdxW-1:0]  enc_idx;
  logic             enc_valid;
  logic             ie_wr, if_wr, ack_eff;

  // Reads have no side effects, and din bits above N_IRQ are ignored.
  logic unused_bits;
  assign unused_bits = ^{rd_i, din_i};

`ifdef IRQ_EDGE_DETECT_EN
  logic [N_IRQ-1:0] req_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) req_q <= '0;
    else       req_q <= irq_req_i;
  end

  assign set_vec = irq_req_i & ~req_q;
`else
  assign set_vec = irq_req_i;
`endif

  irq_prio_enc #(
    .N (N_IRQ)
  ) u_prio_enc (
    .req_i   (ie_q & if_q),
    .idx_o   (enc_idx),
    .valid_o (enc_valid)
  );

  assign ie_wr   = wr_i && (a_i == IE_ADDR);
  assign if_wr   = wr_i && (a_i == IF_ADDR);
  assign ack_eff = irq_ack_i && pending_q;

  // Request beats CPU write beats ack, so a request coinciding with its own ack survives.
  // The ack clears the source named by the registered vector.
  always_comb begin
    ie_d = ie_q;
    if_d = if_q;
    if (ie_wr) ie_d = din_i[N_IRQ-1:0];
    for (int i = 0; i < int'(N_IRQ); i++) begin
      if (set_vec[i])                          if_d[i] = 1'b1;
      else if (if_wr)                          if_d[i] = din_i[i];
      else if (ack_eff && idx_q == IdxW'(i))   if_d[i] = 1'b0;
    end
  end

  always_comb begin
    pending_d = enc_valid;
    idx_d     = enc_idx;
    vector_d  = irq_vec_calc(VEC_BASE, VEC_STRIDE, 8'(enc_idx));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ie_q      <= '0;
      if_q      <= '0;
      pending_q <= 1'b0;
      vector_q  <= VEC_BASE;
      idx_q     <= '0;
    end else begin
      ie_q      <= ie_d;
      if_q      <= if_d;
      pending_q <= pending_d;
      vector_q  <= vector_d;
      idx_q     <= idx_d;
    end
  end

  always_comb begin
    dout_o = 8'hFF;
    hit_o  = 1'b0;
    if (a_i == IE_ADDR) begin
      hit_o               = 1'b1;
      dout_o[N_IRQ-1:0]   = ie_q;
    end else if (a_i == IF_ADDR) begin
      hit_o               = 1'b1;
      dout_o[N_IRQ-1:0]   = if_q;
    end
  end

  assign irq_pending_o = pending_q;
  assign irq_vector_o  = vector_q;
  assign ie_out_o      = ie_q;
  assign if_out_o      = if_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl with N_IRQ=5 and default addresses/vectors.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        rd, wr, hit;
  logic [4:0]  irq_req;
  logic        irq_pending;
  logic [7:0]  irq_vector;
  logic        irq_ack;
  logic [4:0]  ie_out, if_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  irq_ctrl dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .a_i           (a),
    .din_i         (din),
    .dout_o        (dout),
    .rd_i          (rd),
    .wr_i          (wr),
    .hit_o         (hit),
    .irq_req_i     (irq_req),
    .irq_pending_o (irq_pending),
    .irq_vector_o  (irq_vector),
    .irq_ack_i     (irq_ack),
    .ie_out_o      (ie_out),
    .if_out_o      (if_out)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [15:0] addr, input logic [7:0] data);
    a   = addr;
    din = data;
    wr  = 1'b1;
    tick();
    wr  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; a = 16'h0000; din = 8'h00; rd = 1'b0; wr = 1'b0;
    irq_req = '0; irq_ack = 1'b0;
    tick();
    tick();
    chk("rst_ie", 8'(ie_out), 8'h00);
    chk("rst_if", 8'(if_out), 8'h00);
    chk("rst_pend", 8'(irq_pending), 8'h00);
    chk("rst_vec", irq_vector, 8'h40);
    rst = 1'b0;

    rd = 1'b1; a = 16'hFF0F; #1;
    chk("rd_if_dout", dout, 8'hE0);
    chk("rd_if_hit", 8'(hit), 8'h01);
    a = 16'hFF10; #1;
    chk("miss_hit", 8'(hit), 8'h00);
    chk("miss_dout", dout, 8'hFF);
    rd = 1'b0;

    wr_reg(16'hFFFF, 8'h1F);
    chk("ie_wr", 8'(ie_out), 8'h1F);
    a = 16'hFFFF; #1;
    chk("rd_ie_dout", dout, 8'hFF);

    // Single timer request
    irq_req = 5'b00100; tick(); irq_req = '0;
    chk("timer_if", 8'(if_out), 8'h04);
    chk("timer_pend_lag", 8'(irq_pending), 8'h00);
    tick();
    chk("timer_pend", 8'(irq_pending), 8'h01);
    chk("timer_vec", irq_vector, 8'h50);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("timer_ack_if", 8'(if_out), 8'h00);
    tick();
    chk("timer_ack_pend", 8'(irq_pending), 8'h00);
    chk("timer_ack_vec", irq_vector, 8'h40);

    // Priority chain 10110
    wr_reg(16'hFF0F, 8'h16);
    chk("chain_if", 8'(if_out), 8'h16);
    tick();
    chk("chain_pend", 8'(irq_pending), 8'h01);
    chk("chain_vec0", irq_vector, 8'h48);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("chain_if1", 8'(if_out), 8'h14);
    tick();
    chk("chain_vec1", irq_vector, 8'h50);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("chain_if2", 8'(if_out), 8'h10);
    tick();
    chk("chain_vec2", irq_vector, 8'h60);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("chain_if3", 8'(if_out), 8'h00);
    tick();
    chk("chain_pend_end", 8'(irq_pending), 8'h00);

    // Ack and re-request of the same bit in one cycle
    wr_reg(16'hFF0F, 8'h02);
    tick();
    chk("same_vec", irq_vector, 8'h48);
    irq_ack = 1'b1; irq_req = 5'b00010; tick(); irq_ack = 1'b0; irq_req = '0;
    chk("same_if", 8'(if_out), 8'h02);
    tick();
    chk("same_pend", 8'(irq_pending), 8'h01);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    tick();

    // IE=0 retains flags; ack without pending is ignored
    wr_reg(16'hFFFF, 8'h00);
    wr_reg(16'hFF0F, 8'h01);
    tick();
    chk("ie0_pend", 8'(irq_pending), 8'h00);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("ie0_ack_ignored", 8'(if_out), 8'h01);

    // IE write coinciding with ack uses the old selection
    wr_reg(16'hFFFF, 8'h1F);
    wr_reg(16'hFF0F, 8'h05);
    tick();
    chk("iew_vec0", irq_vector, 8'h40);
    irq_ack = 1'b1; a = 16'hFFFF; din = 8'h04; wr = 1'b1;
    tick();
    irq_ack = 1'b0; wr = 1'b0;
    chk("iew_if", 8'(if_out), 8'h04);
    chk("iew_ie", 8'(ie_out), 8'h04);
    tick();
    chk("iew_vec1", irq_vector, 8'h50);

    // CPU clearing IF while vblank request arrives
    a = 16'hFF0F; din = 8'h00; wr = 1'b1; irq_req = 5'b00001;
    tick();
    wr = 1'b0; irq_req = '0;
    chk("wr_vs_req_if", 8'(if_out), 8'h01);
    wr_reg(16'hFF0F, 8'h00);
    tick();

    // Held serial level
    wr_reg(16'hFFFF, 8'h08);
    irq_req = 5'b01000;
    tick();
    chk("lvl_if", 8'(if_out), 8'h08);
    tick();
    chk("lvl_vec", irq_vector, 8'h58);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
`ifdef IRQ_EDGE_DETECT_EN
    chk("lvl_ack_if", 8'(if_out), 8'h00);
    tick();
    chk("lvl_after_if", 8'(if_out), 8'h00);
    chk("lvl_after_pend", 8'(irq_pending), 8'h00);
`else
    chk("lvl_ack_if", 8'(if_out), 8'h08);
    tick();
    chk("lvl_after_if", 8'(if_out), 8'h08);
    chk("lvl_after_pend", 8'(irq_pending), 8'h01);
`endif
    for (int i = 0; i < 5; i++) tick();
    irq_req = '0; tick();
    wr_reg(16'hFF0F, 8'h00);
    irq_req = 5'b01000; tick();
    chk("lvl_reraise_if", 8'(if_out), 8'h08);
    tick();
    chk("lvl_reraise_pend", 8'(irq_pending), 8'h01);
    irq_req = '0;

    // Asynchronous reset during an ack
    irq_ack = 1'b1; #2; rst = 1'b1; #1;
    chk("rst_mid_if", 8'(if_out), 8'h00);
    chk("rst_mid_ie", 8'(ie_out), 8'h00);
    chk("rst_mid_pend", 8'(irq_pending), 8'h00);
    chk("rst_mid_vec", irq_vector, 8'h40);
    irq_ack = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
